// File: rtl/rev_seq_ctrl.sv
// rev_seq_ctrl: multi-cycle bit reverser, out[i] = in[WIDTH-1-i].
// One CHUNK-bit slice is reversed per cycle behind a valid/ready handshake
// on each side. Optional build macro REVSEQ_PARITY_EN adds out_parity, the
// XOR of the result word, accumulated chunk by chunk.
module rev_seq_ctrl #(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned CHUNK = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef REVSEQ_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  // One-hot so the handshake outputs are single register bits.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StDone = 3'b100
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;

  logic [WIDTH-1:0] src_shift;
  logic [CHUNK-1:0] slice;
  logic [CHUNK-1:0] slice_rev;
  logic [WIDTH-1:0] chunk_place;

`ifdef REVSEQ_PARITY_EN
  logic par_q, par_d;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, N chunk cycles in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid)           state_d = StRun;
      StRun:  if (cnt_q == CntLast)   state_d = StDone;
      StDone: if (out_ready)          state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded straight from the state bits.
  always_comb begin
    in_ready  = state_q[0];
    out_valid = state_q[2];
    busy      = state_q[1] | state_q[2];
    out_data  = dst_q;
  end

  // Slice select and reversal for the current chunk index.
  always_comb begin
    src_shift = src_q >> (CHUNK * cnt_q);
    slice     = src_shift[CHUNK-1:0];
    slice_rev = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      slice_rev[i] = slice[CHUNK-1-i];
    end
    // dst is cleared on acceptance, so OR-ing the placed chunk is a write.
    chunk_place = WIDTH'(slice_rev) << (CHUNK * (N - 1 - cnt_q));
  end

  // Datapath next-state: capture on acceptance, accumulate during RUN.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
`ifdef REVSEQ_PARITY_EN
    par_d = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          src_d = in_data;
          dst_d = '0;
          cnt_d = '0;
`ifdef REVSEQ_PARITY_EN
          par_d = 1'b0;
`endif
        end
      end
      StRun: begin
        dst_d = dst_q | chunk_place;
`ifdef REVSEQ_PARITY_EN
        par_d = par_q ^ (^slice_rev);
`endif
        // Counter stops at the last chunk rather than wrapping.
        if (cnt_q != CntLast) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef REVSEQ_PARITY_EN
  // Parity accumulator, held with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  // Parity output.
  always_comb begin
    out_parity = par_q;
  end
`endif

endmodule

// File: tb/tb_rev_seq_ctrl.sv
// Self-checking bench for rev_seq_ctrl (WIDTH=100, CHUNK=10) with a
// reference-reversal scoreboard. Honours REVSEQ_PARITY_EN.
module tb_rev_seq_ctrl;

  localparam int unsigned W = 100;
  localparam int unsigned C = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] out_data;
`ifdef REVSEQ_PARITY_EN
  logic         out_parity;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cyc[$];
  logic [W-1:0] sb_q[$];
  logic [W-1:0] mon_exp;

  rev_seq_ctrl #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef REVSEQ_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev_ref(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = x[W-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(rev_ref(in_data));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", W'(sb_q.size()), W'(1));
        end else begin
          mon_exp = sb_q.pop_front();
          check("sb_data", out_data, mon_exp);
`ifdef REVSEQ_PARITY_EN
          check("sb_parity", W'(out_parity), W'(^mon_exp));
`endif
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", W'(in_ready), W'(1));
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_timeout", W'(out_valid), W'(1));
  endtask

  task automatic recv(input int delay);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] w;
    logic [W-1:0] exp_v;
    int n;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_out_data", out_data, '0);
    #2;
    rst_n = 1'b1;

    // Single bit: latency and MSB placement.
    send(W'(1));
    wait_out(lat);
    check("latency", W'(lat), W'(10));
    exp_v = '0;
    exp_v[W-1] = 1'b1;
    check("single_bit", out_data, exp_v);
    check("done_busy", W'(busy), W'(1));
    check("done_in_ready", W'(in_ready), W'(0));
    recv(0);

    // All ones and two LSBs.
    send('1);
    wait_out(lat);
    check("all_ones", out_data, '1);
    recv(0);
    send(W'(3));
    wait_out(lat);
    exp_v = '0;
    exp_v[W-1] = 1'b1;
    exp_v[W-2] = 1'b1;
    check("two_msb", out_data, exp_v);
    recv(1);

    // Backpressure: result must hold for 5 stalled cycles.
    w = rnd();
    send(w);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_data", out_data, rev_ref(w));
      check("bp_valid", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_busy", W'(busy), W'(1));
    end
    recv(0);
    check("bp_idle_ready", W'(in_ready), W'(1));
    check("bp_idle_valid", W'(out_valid), W'(0));
    check("bp_idle_busy", W'(busy), W'(0));

    // Random words with random consumer delay.
    for (int k = 0; k < 11; k++) begin
      send(rnd());
      wait_out(lat);
      recv($urandom_range(0, 2));
    end

    // Back-to-back: in_valid and out_ready held high, A then B.
    acc_cyc.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = rnd();
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_data = rnd();
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    check("b2b_count", W'(acc_cyc.size()), W'(2));
    if (acc_cyc.size() == 2) check("b2b_period", W'(acc_cyc[1] - acc_cyc[0]), W'(12));

    // Asynchronous reset mid-RUN at cnt=4.
    send('1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_out_data", out_data, '0);
    sb_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));
    w = rnd();
    send(w);
    wait_out(lat);
    check("post_rst_latency", W'(lat), W'(10));
    check("post_rst_data", out_data, rev_ref(w));
    recv(0);

`ifdef REVSEQ_PARITY_EN
    send(W'(7));
    wait_out(lat);
    check("parity_7", W'(out_parity), W'(1));
    recv(0);
    send(W'(3));
    wait_out(lat);
    check("parity_3", W'(out_parity), W'(0));
    recv(0);
`endif

    check("sb_drained", W'(sb_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
